// File: rtl/xbar_pkg.sv
// Shared types and helpers for the tagged round-robin crossbar.
package xbar_pkg;

    localparam int DROP_CNT_WIDTH = 32;
    localparam int MAX_PORTS      = 32;

    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int keep_width(input int bits);
        return (bits + 7) / 8;
    endfunction

    // First requester at or after ptr, wrapping modulo n; one-hot result.
    function automatic logic [MAX_PORTS-1:0] rr_pick(
        input logic [MAX_PORTS-1:0] req,
        input int                   n,
        input int                   ptr
    );
        logic [MAX_PORTS-1:0] gnt;
        logic                 found;
        int                   idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/xbar_if.sv
// Stream interfaces: tagged inputs and plain data outputs.
interface tagged_i
    import xbar_pkg::*;
#(
    parameter type data_t     = logic [31:0],
    parameter int  TAG_WIDTH  = 2,
    parameter int  KEEP_WIDTH = keep_width($bits(data_t))
);
    data_t                 data;
    logic [TAG_WIDTH-1:0]  tag;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic                  valid;
    logic                  ready;

    modport s (input data, tag, keep, last, valid, output ready);
    modport m (output data, tag, keep, last, valid, input ready);
endinterface

interface data_i
    import xbar_pkg::*;
#(
    parameter type data_t     = logic [31:0],
    parameter int  KEEP_WIDTH = keep_width($bits(data_t))
);
    data_t                 data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic                  valid;
    logic                  ready;

    modport m (output data, keep, last, valid, input ready);
    modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/xbar_out_skid.sv
// Two-entry output skid buffer; ready is registered (not full).
module xbar_out_skid #(
    parameter type data_t     = logic [31:0],
    parameter int  KEEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  data_t                 push_data,
    input  logic [KEEP_WIDTH-1:0] push_keep,
    input  logic                  push_last,
    output logic                  ready,
    output logic                  out_valid,
    output data_t                 out_data,
    output logic [KEEP_WIDTH-1:0] out_keep,
    output logic                  out_last,
    input  logic                  out_ready
);

    data_t                 data_q [2];
    logic [KEEP_WIDTH-1:0] keep_q [2];
    logic                  last_q [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic [1:0]            count_nx;
    logic                  do_push;
    logic                  do_pop;

    assign do_push   = push && ready;
    assign do_pop    = out_valid && out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = data_q[rd_ptr];
    assign out_keep  = keep_q[rd_ptr];
    assign out_last  = last_q[rd_ptr];

    always_comb begin
        count_nx = count;
        if (do_push) count_nx = count_nx + 2'd1;
        if (do_pop)  count_nx = count_nx - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            ready  <= 1'b1;
            for (int e = 0; e < 2; e++) begin
                data_q[e] <= '0;
                keep_q[e] <= '0;
                last_q[e] <= 1'b0;
            end
        end else begin
            count <= count_nx;
            ready <= (count_nx != 2'd2);
            if (do_push) begin
                data_q[wr_ptr] <= push_data;
                keep_q[wr_ptr] <= push_keep;
                last_q[wr_ptr] <= push_last;
                wr_ptr         <= !wr_ptr;
            end
            if (do_pop) rd_ptr <= !rd_ptr;
        end
    end

endmodule

// File: rtl/tagged_rr_crossbar.sv
// Tagged stream crossbar: per-output round-robin with packet lock and skid.
// Drop statistics port enabled by defining TAGGED_XBAR_STATS_EN.
module tagged_rr_crossbar
    import xbar_pkg::*;
#(
    parameter type data_t        = logic [31:0],
    parameter int  NUM_INPUTS    = 4,
    parameter int  NUM_OUTPUTS   = 4,
    parameter int  TAG_WIDTH     = min1_clog2(NUM_OUTPUTS),
    parameter bit  LAST_HANDLING = 1'b1,
    parameter bit  FILTER_KEEP   = 1'b1
) (
    input logic clk,
    input logic rst_n,
    tagged_i.s  in  [NUM_INPUTS],
    data_i.m    out [NUM_OUTPUTS]
`ifdef TAGGED_XBAR_STATS_EN
    ,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
`endif
);

    localparam int KW = keep_width($bits(data_t));
    localparam int IW = min1_clog2(NUM_INPUTS);

    data_t                in_data  [NUM_INPUTS];
    logic [TAG_WIDTH-1:0] in_tag   [NUM_INPUTS];
    logic [KW-1:0]        in_keep  [NUM_INPUTS];
    logic                 in_last  [NUM_INPUTS];
    logic                 in_valid [NUM_INPUTS];
    logic                 in_drop  [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] grant   [NUM_OUTPUTS];
    logic                 skid_ready [NUM_OUTPUTS];

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
        logic                 rdy;
        logic                 in_pkt;
        logic [TAG_WIDTH-1:0] pkt_tag;

        assign in_data[i]  = in[i].data;
        assign in_tag[i]   = in[i].tag;
        assign in_keep[i]  = in[i].keep;
        assign in_last[i]  = in[i].last;
        assign in_valid[i] = in[i].valid;
        // Drops never touch arbitration; they are swallowed here.
        assign in_drop[i]  = (int'(in[i].tag) >= NUM_OUTPUTS) ||
                             (FILTER_KEEP && (in[i].keep == '0) && !in[i].last);

        always_comb begin
            rdy = in_drop[i];
            for (int o = 0; o < NUM_OUTPUTS; o++)
                if (int'(in_tag[i]) == o && grant[o][i] && skid_ready[o])
                    rdy = 1'b1;
        end

        assign in[i].ready = rst_n && rdy;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                in_pkt  <= 1'b0;
                pkt_tag <= '0;
            end else begin
                if (in_valid[i] && in_pkt)
                    assert (in_tag[i] == pkt_tag);
                if (in_valid[i] && rdy) begin
                    in_pkt  <= !in_last[i];
                    pkt_tag <= in_tag[i];
                end
            end
        end
    end

    for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
        logic [NUM_INPUTS-1:0] req;
        logic [NUM_INPUTS-1:0] gnt;
        logic [MAX_PORTS-1:0]  req_ext;
        logic [MAX_PORTS-1:0]  pick;
        logic                  locked;
        logic [IW-1:0]         lock_idx;
        logic [IW-1:0]         rr_ptr;
        logic [IW-1:0]         gnt_idx;
        logic                  accept;
        data_t                 push_data;
        logic [KW-1:0]         push_keep;
        logic                  push_last;

        always_comb begin
            req = '0;
            for (int i = 0; i < NUM_INPUTS; i++)
                req[i] = in_valid[i] && !in_drop[i] && int'(in_tag[i]) == o;
            req_ext = '0;
            req_ext[NUM_INPUTS-1:0] = req;
            pick = rr_pick(req_ext, NUM_INPUTS, int'(rr_ptr));
            gnt = '0;
            if (locked) gnt[lock_idx] = req[lock_idx];
            else        gnt = pick[NUM_INPUTS-1:0];
            gnt_idx   = '0;
            push_data = '0;
            push_keep = '0;
            push_last = 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (gnt[i]) begin
                    gnt_idx   = IW'(i);
                    push_data = in_data[i];
                    push_keep = in_keep[i];
                    push_last = in_last[i];
                end
            end
        end

        assign grant[o] = gnt;
        assign accept   = (|gnt) && skid_ready[o];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                locked   <= 1'b0;
                lock_idx <= '0;
                rr_ptr   <= '0;
            end else if (accept) begin
                if (LAST_HANDLING && !push_last) begin
                    locked   <= 1'b1;
                    lock_idx <= gnt_idx;
                end else begin
                    locked <= 1'b0;
                    rr_ptr <= (int'(gnt_idx) == NUM_INPUTS - 1) ?
                              '0 : gnt_idx + IW'(1);
                end
            end
        end

        xbar_out_skid #(
            .data_t     (data_t),
            .KEEP_WIDTH (KW)
        ) u_skid (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (accept),
            .push_data (push_data),
            .push_keep (push_keep),
            .push_last (push_last),
            .ready     (skid_ready[o]),
            .out_valid (out[o].valid),
            .out_data  (out[o].data),
            .out_keep  (out[o].keep),
            .out_last  (out[o].last),
            .out_ready (out[o].ready)
        );
    end

`ifdef TAGGED_XBAR_STATS_EN
    logic [DROP_CNT_WIDTH:0] drop_sum;

    always_comb begin
        drop_sum = {1'b0, drop_count};
        for (int i = 0; i < NUM_INPUTS; i++)
            if (in_valid[i] && in_drop[i])
                drop_sum = drop_sum + (DROP_CNT_WIDTH+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      drop_count <= '0;
        else if (drop_sum[DROP_CNT_WIDTH]) drop_count <= '1;
        else                             drop_count <= drop_sum[DROP_CNT_WIDTH-1:0];
    end
`endif

endmodule

// File: tb/tb_tagged_rr_crossbar.sv
// Directed bench for tagged_rr_crossbar: a 4x4 and a 3x3 instance.
module tb_tagged_rr_crossbar;
    import xbar_pkg::*;

    typedef logic [15:0] word_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic        v [4], l [4], r [4];
    word_t       d [4];
    logic [1:0]  t [4], k [4];
    logic        ov [4], ol [4], ordy [4];
    word_t       od [4];
    logic [1:0]  ok [4];

    logic        bv [3], bl [3], br [3];
    word_t       bd [3];
    logic [1:0]  bt [3], bk [3];
    logic        bov [3], bol [3], bordy [3];
    word_t       bod [3];
    logic [1:0]  bok [3];

    tagged_i #(.data_t(word_t), .TAG_WIDTH(2)) ta [4] ();
    data_i   #(.data_t(word_t))                da [4] ();
    tagged_i #(.data_t(word_t), .TAG_WIDTH(2)) tb [3] ();
    data_i   #(.data_t(word_t))                db [3] ();

`ifdef TAGGED_XBAR_STATS_EN
    logic [31:0] a_drop;
    logic [31:0] b_drop;
`endif

    for (genvar g = 0; g < 4; g++) begin : g_a
        assign ta[g].valid = v[g];
        assign ta[g].data  = d[g];
        assign ta[g].tag   = t[g];
        assign ta[g].keep  = k[g];
        assign ta[g].last  = l[g];
        assign r[g]        = ta[g].ready;
        assign ov[g]       = da[g].valid;
        assign od[g]       = da[g].data;
        assign ok[g]       = da[g].keep;
        assign ol[g]       = da[g].last;
        assign da[g].ready = ordy[g];
    end

    for (genvar g = 0; g < 3; g++) begin : g_b
        assign tb[g].valid = bv[g];
        assign tb[g].data  = bd[g];
        assign tb[g].tag   = bt[g];
        assign tb[g].keep  = bk[g];
        assign tb[g].last  = bl[g];
        assign br[g]       = tb[g].ready;
        assign bov[g]      = db[g].valid;
        assign bod[g]      = db[g].data;
        assign bok[g]      = db[g].keep;
        assign bol[g]      = db[g].last;
        assign db[g].ready = bordy[g];
    end

    tagged_rr_crossbar #(
        .data_t      (word_t),
        .NUM_INPUTS  (4),
        .NUM_OUTPUTS (4)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (ta),
        .out   (da)
`ifdef TAGGED_XBAR_STATS_EN
        ,
        .drop_count (a_drop)
`endif
    );

    tagged_rr_crossbar #(
        .data_t      (word_t),
        .NUM_INPUTS  (3),
        .NUM_OUTPUTS (3)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (tb),
        .out   (db)
`ifdef TAGGED_XBAR_STATS_EN
        ,
        .drop_count (b_drop)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 4; i++) begin
            v[i] = 1'b0; d[i] = '0; t[i] = '0;
            k[i] = 2'b11; l[i] = 1'b1; ordy[i] = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            bv[i] = 1'b0; bd[i] = '0; bt[i] = '0;
            bk[i] = 2'b11; bl[i] = 1'b1; bordy[i] = 1'b1;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int    exp_seq [6] = '{0, 1, 3, 0, 1, 3};
    logic [2:0] exp_oh [6] = '{3'b001, 3'b010, 3'b100,
                               3'b001, 3'b010, 3'b100};

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();

        // Reset state: drop-type beat must still see ready low
        v[0] = 1'b1; k[0] = 2'b00; l[0] = 1'b0;
        tick();
        #1;
        chk("rst_ready", 32'(r[0]), 32'd0);
        chk("rst_valid", 32'({ov[0], ov[1], ov[2], ov[3]}), 32'd0);
`ifdef TAGGED_XBAR_STATS_EN
        chk("rst_drop_count", a_drop, 32'd0);
`endif
        clear_inputs();
        rst_n = 1'b1;
        tick();

        // Routing: input 2 to each output
        for (int tg = 0; tg < 4; tg++) begin
            v[2] = 1'b1; t[2] = 2'(tg); d[2] = 16'h00A0 + 16'(tg);
            #1;
            chk("route_rdy", 32'(r[2]), 32'd1);
            tick();
            v[2] = 1'b0;
            #1;
            for (int j = 0; j < 4; j++)
                chk("route_valid", 32'(ov[j]), 32'(j == tg));
            chk("route_data", 32'(od[tg]), 32'h00A0 + 32'(tg));
        end

        // Fairness: inputs 0,1,3 contend for output 1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i != 2) begin
                v[i] = 1'b1; t[i] = 2'd1; d[i] = 16'h0100 + 16'(i);
            end
        end
        for (int c = 0; c < 7; c++) begin
            #1;
            if (c > 0) begin
                chk("fair_valid", 32'(ov[1]), 32'd1);
                chk("fair_data", 32'(od[1]), 32'h0100 + 32'(exp_seq[c-1]));
            end
            if (c < 6)
                chk("fair_grant", 32'({r[3], r[1], r[0]}), 32'(exp_oh[c]));
            tick();
        end

        // Packet lock: input 0 holds output 2 for 4 beats
        do_reset();
        v[0] = 1'b1; t[0] = 2'd2; l[0] = 1'b0; d[0] = 16'h0300;
        #1;
        chk("lock_b0_rdy", 32'(r[0]), 32'd1);
        tick();
        v[1] = 1'b1; t[1] = 2'd2; l[1] = 1'b1; d[1] = 16'h0200;
        for (int b = 1; b < 4; b++) begin
            d[0] = 16'h0300 + 16'(b);
            l[0] = (b == 3);
            #1;
            chk("lock_wait", 32'(r[1]), 32'd0);
            chk("lock_owner", 32'(r[0]), 32'd1);
            chk("lock_out", 32'(od[2]), 32'h0300 + 32'(b - 1));
            tick();
        end
        v[0] = 1'b0;
        #1;
        chk("lock_next_rdy", 32'(r[1]), 32'd1);
        chk("lock_last_data", 32'(od[2]), 32'h0303);
        chk("lock_last_flag", 32'(ol[2]), 32'd1);
        tick();
        v[1] = 1'b0;
        #1;
        chk("lock_next_valid", 32'(ov[2]), 32'd1);
        chk("lock_next_data", 32'(od[2]), 32'h0200);
        tick();

        // Non-blocking: output 0 stalled, output 3 streams
        do_reset();
        ordy[0] = 1'b0;
        v[0] = 1'b1; t[0] = 2'd0;
        v[1] = 1'b1; t[1] = 2'd3;
        for (int c = 0; c < 6; c++) begin
            d[0] = 16'h0400 + 16'((c < 2) ? c : 2);
            d[1] = 16'h0500 + 16'(c);
            #1;
            chk("nb_in0_rdy", 32'(r[0]), 32'(c < 2));
            chk("nb_in1_rdy", 32'(r[1]), 32'd1);
            if (c > 0)
                chk("nb_out3", 32'(od[3]), 32'h0500 + 32'(c - 1));
            tick();
        end
        v[1] = 1'b0;
        ordy[0] = 1'b1;
        #1;
        chk("nb_hold_valid", 32'(ov[0]), 32'd1);
        chk("nb_hold_data", 32'(od[0]), 32'h0400);
        chk("nb_full_rdy", 32'(r[0]), 32'd0);
        tick();
        #1;
        chk("nb_drain1", 32'(od[0]), 32'h0401);
        chk("nb_reopen_rdy", 32'(r[0]), 32'd1);
        tick();
        v[0] = 1'b0;
        #1;
        chk("nb_drain2", 32'(od[0]), 32'h0402);
        tick();

        // Drops on 3x3: tag 3, keep=0/last=0; keep=0/last=1 forwarded
        do_reset();
        bv[0] = 1'b1; bt[0] = 2'd3; bk[0] = 2'b11; bl[0] = 1'b1; bd[0] = 16'h0800;
        bv[1] = 1'b1; bt[1] = 2'd0; bk[1] = 2'b00; bl[1] = 1'b0; bd[1] = 16'h0801;
        bv[2] = 1'b1; bt[2] = 2'd1; bk[2] = 2'b00; bl[2] = 1'b1; bd[2] = 16'h0802;
        #1;
        chk("drop_tag_rdy", 32'(br[0]), 32'd1);
        chk("drop_keep_rdy", 32'(br[1]), 32'd1);
        chk("fwd_keep0_rdy", 32'(br[2]), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) bv[i] = 1'b0;
        #1;
        chk("drop_out0_valid", 32'(bov[0]), 32'd0);
        chk("drop_out2_valid", 32'(bov[2]), 32'd0);
        chk("fwd_valid", 32'(bov[1]), 32'd1);
        chk("fwd_data", 32'(bod[1]), 32'h0802);
        chk("fwd_keep", 32'(bok[1]), 32'd0);
        chk("fwd_last", 32'(bol[1]), 32'd1);
`ifdef TAGGED_XBAR_STATS_EN
        chk("drop_count", b_drop, 32'd2);
`endif
        tick();

        // Reset mid-packet
        do_reset();
        v[0] = 1'b1; t[0] = 2'd1; l[0] = 1'b0; d[0] = 16'h0600;
        v[2] = 1'b1; t[2] = 2'd1; l[2] = 1'b1; d[2] = 16'h0700;
        #1;
        chk("mrst_b0_rdy", 32'(r[0]), 32'd1);
        chk("mrst_other_wait", 32'(r[2]), 32'd0);
        tick();
        d[0] = 16'h0601;
        #1;
        chk("mrst_locked", 32'(r[2]), 32'd0);
        tick();
        d[0] = 16'h0602;
        #1;
        chk("mrst_pre_valid", 32'(ov[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid_drop", 32'(ov[1]), 32'd0);
        chk("mrst_rdy_low", 32'(r[2]), 32'd0);
        tick();
        v[0] = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("mrst_fresh_rdy", 32'(r[2]), 32'd1);
        tick();
        v[2] = 1'b0;
        #1;
        chk("mrst_fresh_valid", 32'(ov[1]), 32'd1);
        chk("mrst_fresh_data", 32'(od[1]), 32'h0700);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
